// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the CPU's unified memory: CPU port vs. loader/debug port.
// Default round-robin on ties; define ARB_CPU_PRIORITY_EN for fixed CPU priority.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic [DW-1:0] aux_rdata,
    output logic          aux_ready,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_re,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant_id
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_grant_q, last_grant_d;
    logic            grant_q, grant_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            win;
    logic            read_done;
    logic [DW-1:0]   rdata_q [2];
    logic            ready_w [2];

    // win is only consulted when at least one port is requesting (0 = CPU, 1 = aux)
    always_comb begin
`ifdef ARB_CPU_PRIORITY_EN
        win = ~cpu_req;
`else
        win = (cpu_req && aux_req) ? ~last_grant_q : ~cpu_req;
`endif
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        case (state_q)
            IDLE: begin
                if (cpu_req || aux_req) begin
                    grant_d = win;
                    we_d    = win ? aux_we    : cpu_we;
                    addr_d  = win ? aux_addr  : cpu_addr;
                    wdata_d = win ? aux_wdata : cpu_wdata;
                    cnt_d   = CW'(MEM_LAT - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Memory data is only valid in the final ACCESS cycle, and only reads update rdata
    assign read_done = (state_q == ACCESS) && (cnt_q == '0) && !we_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q[gi] <= '0;
            end else if (read_done && (grant_q == 1'(gi))) begin
                rdata_q[gi] <= mem_rdata;
            end
        end
        assign ready_w[gi] = (state_q == RESP) && (grant_q == 1'(gi));
    end

    assign cpu_rdata = rdata_q[0];
    assign aux_rdata = rdata_q[1];
    assign cpu_ready = ready_w[0];
    assign aux_ready = ready_w[1];

    assign mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
    assign mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign mem_re    = (state_q == ACCESS) && !we_q;
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (MEM_LAT=2) with a small word-addressed memory model.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, aux_req, aux_we;
    logic [AW-1:0] cpu_addr, aux_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, aux_wdata, cpu_rdata, aux_rdata, mem_wdata, mem_rdata;
    logic          cpu_ready, aux_ready, mem_re, mem_we, busy, grant_id;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_rdata(aux_rdata), .aux_ready(aux_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          port;
        logic [DW-1:0] cpu_rd;
        logic [DW-1:0] aux_rd;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            re_cnt = 0;
    int            we_cnt = 0;
    logic [DW-1:0] mem_model [0:63];
    logic [DW-1:0] exp_cpu, exp_aux;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            mem_model[4] <= 32'h8C01_0004;
            mem_model[8] <= 32'h1234_5678;
        end else if (mem_we) begin
            mem_model[mem_addr[7:2]] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re) mem_rdata = mem_model[mem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_re) re_cnt++;
        if (mem_we) we_cnt++;
    end

    // Monitor: every ready pulse must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (cpu_ready || aux_ready) begin
            if (cpu_ready && aux_ready) begin
                chk("both_ready", {cpu_ready, aux_ready}, 2'b01);
            end else if (sb.size() == 0) begin
                chk("unexpected_ready", {cpu_ready, aux_ready}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_port", aux_ready, e.port);
                chk("grant_id", grant_id, e.port);
                chk("ready_cycle", cyc, e.cyc);
                chk("cpu_rdata", cpu_rdata, e.cpu_rd);
                chk("aux_rdata", aux_rdata, e.aux_rd);
                $display("txn port=%0d cycle=%0d cpu_rdata=%h aux_rdata=%h",
                         aux_ready, cyc, cpu_rdata, aux_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic port, input int c);
        exp_t e;
        e.port   = port;
        e.cpu_rd = exp_cpu;
        e.aux_rd = exp_aux;
        e.cyc    = c;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (sb.size() != 0 && n < budget);
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cpu = '0;
        exp_aux = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rb, wb;
        logic lg, p;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
        rst = 1'b1;
        tick();
        do_reset();

        chk("rst_busy", busy, 1'b0);
        chk("rst_grant_id", grant_id, 1'b0);
        chk("rst_ready", {cpu_ready, aux_ready}, 2'b00);
        chk("rst_strobes", {mem_re, mem_we}, 2'b00);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", {cpu_rdata, aux_rdata}, 64'h0);

        // CPU read of 0x10
        c0 = cyc; rb = re_cnt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        exp_cpu = 32'h8C01_0004;
        push(1'b0, c0 + LAT + 1);
        tick();
        chk("acc_busy", busy, 1'b1);
        chk("acc_mem_addr", mem_addr, 32'h10);
        chk("acc_strobes", {mem_re, mem_we}, 2'b10);
        wait_drain(20);
        cpu_req = 0;
        chk("read_re_cycles", 64'(re_cnt - rb), 64'(LAT));

        // Both ports held: round robin (or CPU-only with fixed priority)
        do_reset();
        c0 = cyc; lg = 1'b1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        aux_req = 1; aux_we = 0; aux_addr = 32'h20;
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_CPU_PRIORITY_EN
            p = 1'b0;
`else
            p = ~lg;
`endif
            lg = p;
            if (p) exp_aux = 32'h1234_5678;
            else   exp_cpu = 32'h8C01_0004;
            push(p, c0 + LAT + 1 + k * (LAT + 2));
        end
        wait_drain(60);
        cpu_req = 0;
        exp_aux = 32'h1234_5678;
        push(1'b1, c0 + LAT + 1 + 5 * (LAT + 2));
        wait_drain(20);
        aux_req = 0;

        // aux write then CPU read of the same word
        c0 = cyc; rb = re_cnt; wb = we_cnt;
        aux_req = 1; aux_we = 1; aux_addr = 32'h40; aux_wdata = 32'hDEAD_BEEF;
        push(1'b1, c0 + LAT + 1);
        wait_drain(20);
        aux_req = 0;
        chk("aux_wr_we_cycles", 64'(we_cnt - wb), 64'(LAT));
        chk("aux_wr_re_cycles", 64'(re_cnt - rb), 64'd0);
        c0 = cyc; rb = re_cnt; wb = we_cnt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
        exp_cpu = 32'hDEAD_BEEF;
        push(1'b0, c0 + LAT + 1);
        wait_drain(20);
        cpu_req = 0;
        chk("cpu_rd_we_cycles", 64'(we_cnt - wb), 64'd0);
        chk("cpu_rd_re_cycles", 64'(re_cnt - rb), 64'(LAT));

        // CPU drops req and scrambles inputs one cycle after grant
        c0 = cyc; wb = we_cnt;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
        exp_cpu = 32'h8C01_0004;
        push(1'b0, c0 + LAT + 1);
        tick();
        cpu_req = 0; cpu_we = 1; cpu_addr = 32'h3C;
        wait_drain(20);
        chk("drop_we_cycles", 64'(we_cnt - wb), 64'd0);

        // Reset in the first ACCESS cycle of a CPU write
        wb = we_cnt;
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h55;
        tick();
        chk("wr_acc_we", mem_we, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0; cpu_req = 0;
        exp_cpu = '0; exp_aux = '0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_mem_we", mem_we, 1'b0);
        chk("abort_rdata", {cpu_rdata, aux_rdata}, 64'h0);
        repeat (8) tick();
        chk("abort_we_cycles", 64'(we_cnt - wb), 64'd1);

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
